// File: rtl/muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit and the ALU control decoder.
package muldiv_pkg;

  localparam int unsigned CNT_W = 6;

  localparam logic [3:0] ALU_MULT = 4'b1101;
  localparam logic [3:0] ALU_DIV  = 4'b1010;
  localparam logic [3:0] ALU_MFHI = 4'b1011;
  localparam logic [3:0] ALU_MFLO = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier, restoring divider and sign-fix logic for ex_muldiv_unit.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             load_div,
  input  logic             mul_step,
  input  logic             div_step,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             mul_last_c,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c
);

  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               div_q, div_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shifted, diff;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_s, rem_s;

  // Load / iterate
  always_comb begin
    abs_a    = rs[WIDTH-1] ? -rs : rs;
    abs_b    = rt[WIDTH-1] ? -rt : rt;
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvsr_q};
    ge       = shifted >= {1'b0, dvsr_q};

    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div_d    = div_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;

    if (load) begin
      neg_a_d  = rs[WIDTH-1];
      neg_b_d  = rt[WIDTH-1];
      div_d    = load_div;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, abs_a};
      mplier_d = abs_b;
      rem_d    = '0;
      quo_d    = abs_a;
      dvsr_d   = abs_b;
    end else if (mul_step) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end else if (div_step) begin
      // remainder always stays below the divisor, so it fits in WIDTH bits
      rem_d = ge ? WIDTH'(diff) : WIDTH'(shifted);
      quo_d = {quo_q[WIDTH-2:0], ge};
    end
  end

  assign mul_last_c = (mplier_q >> 1) == '0;

  // Sign fix; a zero divisor yields all-ones quotient and the original dividend
  always_comb begin
    prod  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_s = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
    rem_s = neg_a_q ? -rem_q : rem_q;
    hi_c  = prod[2*WIDTH-1:WIDTH];
    lo_c  = prod[WIDTH-1:0];
    if (div_q) begin
      hi_c = rem_s;
      lo_c = (dvsr_q == '0) ? {WIDTH{1'b1}} : quo_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
    end else begin
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div_q    <= div_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative signed multiply/divide unit owning HI/LO.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes once the remaining multiplier is zero.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       ex_alu_signal,
  input  logic [WIDTH-1:0] ex_rs_data,
  input  logic [WIDTH-1:0] ex_rt_data,
  input  logic             ex_flush,
  output logic             ex_stall,
  output logic [WIDTH-1:0] ex_hilo_result,
  output logic             ex_hilo_valid,
  output logic             ex_busy
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;

  logic             is_md, is_mf;
  logic             load, load_div, mul_step, div_step;
  logic             mul_last_c;
  logic [WIDTH-1:0] hi_c, lo_c;

  assign is_md    = ex_valid && (ex_alu_signal == ALU_MULT || ex_alu_signal == ALU_DIV);
  assign is_mf    = ex_valid && (ex_alu_signal == ALU_MFHI || ex_alu_signal == ALU_MFLO);
  assign load_div = (ex_alu_signal == ALU_DIV);

  assign ex_stall       = (is_md || is_mf) && (state_q != ST_IDLE);
  assign ex_hilo_valid  = is_mf && (state_q == ST_IDLE);
  assign ex_hilo_result = (ex_alu_signal == ALU_MFHI) ? hi_q : lo_q;
  assign ex_busy        = busy_q;

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_div   (load_div),
    .mul_step   (mul_step),
    .div_step   (div_step),
    .rs         (ex_rs_data),
    .rt         (ex_rt_data),
    .mul_last_c (mul_last_c),
    .hi_c       (hi_c),
    .lo_c       (lo_c)
  );

  // Next-state, counter and HI/LO update; flush overrides everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    load     = 1'b0;
    mul_step = 1'b0;
    div_step = 1'b0;

    if (ex_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_md) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = load_div ? ST_DIV : ST_MUL;
          end
        end
        ST_MUL: begin
          mul_step = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER || (EARLY_EN && mul_last_c)) state_d = ST_FIX;
        end
        ST_DIV: begin
          div_step = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) state_d = ST_FIX;
        end
        ST_FIX: begin
          hi_d    = hi_c;
          lo_d    = lo_c;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (default or MULDIV_EARLY_OUT_EN build).
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_alu_signal = 4'd0;
  logic [31:0] ex_rs_data = '0;
  logic [31:0] ex_rt_data = '0;
  logic        ex_flush = 1'b0;
  logic        ex_stall;
  logic [31:0] ex_hilo_result;
  logic        ex_hilo_valid;
  logic        ex_busy;

  int tests_run = 0;
  int tests_failed = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_alu_signal  (ex_alu_signal),
    .ex_rs_data     (ex_rs_data),
    .ex_rt_data     (ex_rt_data),
    .ex_flush       (ex_flush),
    .ex_stall       (ex_stall),
    .ex_hilo_result (ex_hilo_result),
    .ex_hilo_valid  (ex_hilo_valid),
    .ex_busy        (ex_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  // Issue an op in cycle T, then a back-to-back mflo; report stall cycles and HI/LO read
  task automatic do_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output logic hv, output logic [31:0] lo,
                       output logic [31:0] hi);
    @(negedge clk);
    ex_valid = 1'b1; ex_alu_signal = code; ex_rs_data = a; ex_rt_data = b;
    @(negedge clk);
    ex_alu_signal = ALU_MFLO;
    stalls = 0;
    #1;
    while (ex_stall && stalls < 100) begin
      stalls++;
      @(negedge clk); #1;
    end
    hv = ex_hilo_valid;
    lo = ex_hilo_result;
    ex_alu_signal = ALU_MFHI;
    #1;
    hi = ex_hilo_result;
    ex_valid = 1'b0; ex_alu_signal = 4'd0;
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if (ex_busy !== 1'b0 || ex_stall !== 1'b0 || ex_hilo_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b stall=%b hv=%b, required 0 0 0", ex_busy, ex_stall, ex_hilo_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; ex_valid = 1'b1; ex_alu_signal = ALU_MFHI;
    #1;
    tests_run++;
    if (ex_hilo_valid !== 1'b1 || ex_hilo_result !== 32'h0 || ex_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mfhi: hv=%b hi=%h stall=%b, required 1 00000000 0", ex_hilo_valid, ex_hilo_result, ex_stall);
    end
    ex_alu_signal = ALU_MFLO;
    #1;
    tests_run++;
    if (ex_hilo_result !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mflo: lo=%h, required 00000000", ex_hilo_result);
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_mult_signed();
    int st; logic hv; logic [31:0] lo, hi;
    do_op(ALU_MULT, 32'hFFFF_FFFD, 32'd7, st, hv, lo, hi);
    tests_run++;
    if (st !== (EARLY ? 4 : 33)) begin
      tests_failed++;
      $display("FAIL mult_stall_cycles: got %0d, required %0d", st, EARLY ? 4 : 33);
    end
    tests_run++;
    if (hv !== 1'b1 || lo !== 32'hFFFF_FFEB || hi !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL mult_signed: hv=%b hi=%h lo=%h, required 1 ffffffff ffffffeb", hv, hi, lo);
    end
    do_op(ALU_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, st, hv, lo, hi);
    tests_run++;
    if (st !== (EARLY ? 3 : 33) || lo !== 32'd6 || hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL mult_neg_neg: stalls=%0d hi=%h lo=%h, required %0d 00000000 00000006", st, hi, lo, EARLY ? 3 : 33);
    end
  endtask

  task automatic test_div_signed();
    int st; logic hv; logic [31:0] lo, hi;
    do_op(ALU_DIV, 32'hFFFF_FFEF, 32'd5, st, hv, lo, hi);
    tests_run++;
    if (st !== 33 || hv !== 1'b1) begin
      tests_failed++;
      $display("FAIL div_latency: stalls=%0d hv=%b, required 33 1", st, hv);
    end
    tests_run++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFE) begin
      tests_failed++;
      $display("FAIL div_signed: hi=%h lo=%h, required fffffffe fffffffd", hi, lo);
    end
  endtask

  task automatic test_div_overflow();
    int st; logic hv; logic [31:0] lo, hi;
    do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, hv, lo, hi);
    tests_run++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
      tests_failed++;
      $display("FAIL div_min_neg1: hi=%h lo=%h, required 00000000 80000000", hi, lo);
    end
  endtask

  task automatic test_div_zero();
    int st; logic hv; logic [31:0] lo, hi;
    do_op(ALU_DIV, 32'h1234_5678, 32'h0, st, hv, lo, hi);
    tests_run++;
    if (st !== 33 || lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL div_by_zero: stalls=%0d hi=%h lo=%h, required 33 12345678 ffffffff", st, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    @(negedge clk);
    ex_valid = 1'b1; ex_alu_signal = ALU_MULT; ex_rs_data = 32'd3; ex_rt_data = 32'd5;
    @(negedge clk);
    ex_alu_signal = ALU_DIV; ex_rs_data = 32'd100; ex_rt_data = 32'd7;
    st = 0;
    #1;
    while (ex_stall && st < 100) begin
      st++;
      @(negedge clk); #1;
    end
    tests_run++;
    if (st !== (EARLY ? 4 : 33)) begin
      tests_failed++;
      $display("FAIL b2b_wait: stalls=%0d, required %0d", st, EARLY ? 4 : 33);
    end
    @(negedge clk);
    ex_alu_signal = ALU_MFLO;
    st = 0;
    #1;
    while (ex_stall && st < 100) begin
      st++;
      @(negedge clk); #1;
    end
    tests_run++;
    if (st !== 33 || ex_hilo_result !== 32'd14) begin
      tests_failed++;
      $display("FAIL b2b_div_lo: stalls=%0d lo=%h, required 33 0000000e", st, ex_hilo_result);
    end
    ex_alu_signal = ALU_MFHI;
    #1;
    tests_run++;
    if (ex_hilo_result !== 32'd2) begin
      tests_failed++;
      $display("FAIL b2b_div_hi: hi=%h, required 00000002", ex_hilo_result);
    end
    ex_valid = 1'b0; ex_alu_signal = 4'd0;
  endtask

  task automatic test_flush();
    @(negedge clk);
    ex_valid = 1'b1; ex_alu_signal = ALU_MULT; ex_rs_data = 32'd5; ex_rt_data = 32'h4000_0000;
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk);
    ex_flush = 1'b1;
    #1;
    tests_run++;
    if (ex_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_busy_before: busy=%b, required 1", ex_busy);
    end
    @(negedge clk);
    ex_flush = 1'b0; ex_valid = 1'b1; ex_alu_signal = ALU_MFHI;
    #1;
    tests_run++;
    if (ex_busy !== 1'b0 || ex_stall !== 1'b0 || ex_hilo_valid !== 1'b1 || ex_hilo_result !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL flush_mfhi: busy=%b stall=%b hv=%b hi=%h, required 0 0 1 12345678",
               ex_busy, ex_stall, ex_hilo_valid, ex_hilo_result);
    end
    ex_alu_signal = ALU_MFLO;
    #1;
    tests_run++;
    if (ex_hilo_result !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL flush_mflo: lo=%h, required ffffffff", ex_hilo_result);
    end
    @(negedge clk);
    ex_flush = 1'b1; ex_alu_signal = ALU_MULT;
    @(negedge clk);
    ex_flush = 1'b0; ex_valid = 1'b0;
    #1;
    tests_run++;
    if (ex_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_blocks_accept: busy=%b, required 0", ex_busy);
    end
  endtask

  task automatic test_early_out();
    int st; logic hv; logic [31:0] lo, hi;
    do_op(ALU_MULT, 32'd9, 32'd1, st, hv, lo, hi);
    tests_run++;
    if (st !== (EARLY ? 2 : 33) || lo !== 32'd9 || hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL early_out: stalls=%0d hi=%h lo=%h, required %0d 00000000 00000009", st, hi, lo, EARLY ? 2 : 33);
    end
  endtask

  task automatic test_reset_mid();
    int st;
    @(negedge clk);
    ex_valid = 1'b1; ex_alu_signal = ALU_DIV; ex_rs_data = 32'd1000; ex_rt_data = 32'd3;
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (18) @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    ex_valid = 1'b1; ex_alu_signal = ALU_MFLO;
    #1;
    tests_run++;
    if (ex_busy !== 1'b0 || ex_stall !== 1'b0 || ex_hilo_result !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: busy=%b stall=%b lo=%h, required 0 0 00000000", ex_busy, ex_stall, ex_hilo_result);
    end
    ex_alu_signal = ALU_MULT; ex_rs_data = 32'd3; ex_rt_data = 32'd4;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (ex_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_accept: busy=%b, required 1", ex_busy);
    end
    ex_alu_signal = ALU_MFLO;
    st = 0;
    while (ex_stall && st < 100) begin
      st++;
      @(negedge clk); #1;
    end
    tests_run++;
    if (ex_hilo_result !== 32'd12 || st >= 100) begin
      tests_failed++;
      $display("FAIL reset_mid_result: lo=%h stalls=%0d, required 0000000c", ex_hilo_result, st);
    end
    ex_valid = 1'b0; ex_alu_signal = 4'd0;
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_div_signed();
    test_div_overflow();
    test_back_to_back();
    test_div_zero();
    test_flush();
    test_early_out();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
